// File: rtl/config_loader_pkg.sv
// Shared types and defaults for the fabric configuration loader.
// State encoding and chain sizing live here so top and bench agree.
package config_loader_pkg;

  localparam int DEF_CHAIN_LENGTH = 1024;
  localparam int DEF_CLEAR_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int num_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/config_serializer.sv
// Byte-to-bit datapath: one holding register feeding an 8-bit shift
// register, so a byte every 8 cycles keeps the chain shifting.
module config_serializer (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       active,
  input  logic       take,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       byte_take,
  output logic       bit_valid,
  output logic       bit_out
);

  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] sh_q, sh_d;
  logic [3:0] sh_cnt_q, sh_cnt_d;
  logic       ready_q, ready_d;

  assign byte_ready = ready_q;
  assign byte_take  = byte_valid & ready_q;
  assign bit_valid  = sh_cnt_q != 4'd0;
  assign bit_out    = sh_q[0];

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    sh_cnt_d    = sh_cnt_q;
    if (take && bit_valid) begin
      sh_d     = {1'b0, sh_q[7:1]};
      sh_cnt_d = sh_cnt_q - 4'd1;
    end
    // refill in the same cycle the last bit leaves
    if (sh_cnt_d == 4'd0 && hold_full_q) begin
      sh_d        = hold_q;
      sh_cnt_d    = 4'd8;
      hold_full_d = 1'b0;
    end
    if (byte_take) begin
      hold_d      = byte_data;
      hold_full_d = 1'b1;
    end
    if (clear) begin
      sh_cnt_d    = 4'd0;
      hold_full_d = 1'b0;
    end
    ready_d = active && !hold_full_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      sh_cnt_q    <= '0;
      ready_q     <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      sh_cnt_q    <= sh_cnt_d;
      ready_q     <= ready_d;
    end
  end

endmodule

// File: rtl/config_loader.sv
// Configuration scan-chain loader: clears the chain, shifts the
// bitstream in LSB-first and flags any 1 leaving the cleared chain.
module config_loader
  import config_loader_pkg::*;
#(
  parameter int CHAIN_LENGTH = DEF_CHAIN_LENGTH,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       chain_config_in,
  output logic       chain_config_enable,
  output logic       chain_config_nreset,
  input  logic       chain_config_out,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int BW = $clog2(CHAIN_LENGTH + 1);
  localparam int NBYTES = num_bytes(CHAIN_LENGTH);
  localparam int NW = $clog2(NBYTES + 1);
  localparam int CW =
    (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [BW-1:0] LEN = BW'(CHAIN_LENGTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LENGTH - 1);
  localparam logic [NW-1:0] NB = NW'(NBYTES);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   clr_q, clr_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [NW-1:0]   byte_cnt_q, byte_cnt_d;
  logic            cfg_in_q, cfg_in_d;
  logic            en_q, en_d;
  logic            nrst_q, nrst_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic take, last, act, ser_active, ser_clear;
  logic byte_take, bit_valid, bit_out;

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    bit_d      = bit_q;
    byte_cnt_d = byte_cnt_q + NW'(byte_take);
    cfg_in_d   = 1'b0;
    en_d       = 1'b0;
    nrst_d     = 1'b1;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q | (en_q & chain_config_out);
    take       = 1'b0;
    last       = 1'b0;
    act        = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_CLEAR;
          clr_d      = '0;
          byte_cnt_d = '0;
          nrst_d     = 1'b0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end
      ST_CLEAR: begin
        nrst_d = 1'b0;
        if (clr_q == CLR_LAST) begin
          state_d = ST_LOAD;
          nrst_d  = 1'b1;
          bit_d   = '0;
          act     = 1'b1;
        end else begin
          clr_d = clr_q + CW'(1);
        end
      end
      ST_LOAD: begin
        if (bit_q == LEN) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          if (bit_valid) begin
            take     = 1'b1;
            en_d     = 1'b1;
            cfg_in_d = bit_out;
            bit_d    = bit_q + BW'(1);
            last     = bit_q == LAST_BIT;
          end
          act = !last;
        end
      end
      default: ;
    endcase
    // stop asking once the whole bitstream has been taken
    ser_active = act && (byte_cnt_d < NB);
    ser_clear  = (state_q != ST_LOAD) || last;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clr_q      <= '0;
      bit_q      <= '0;
      byte_cnt_q <= '0;
      cfg_in_q   <= 1'b0;
      en_q       <= 1'b0;
      nrst_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      bit_q      <= bit_d;
      byte_cnt_q <= byte_cnt_d;
      cfg_in_q   <= cfg_in_d;
      en_q       <= en_d;
      nrst_q     <= nrst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  config_serializer u_ser (
    .clock      (clock),
    .reset      (reset),
    .clear      (ser_clear),
    .active     (ser_active),
    .take       (take),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_take  (byte_take),
    .bit_valid  (bit_valid),
    .bit_out    (bit_out)
  );

  assign chain_config_in     = cfg_in_q;
  assign chain_config_enable = en_q;
  assign chain_config_nreset = nrst_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = err_q;

endmodule

// File: tb/tb_config_loader.sv
// Randomised bench for config_loader with a bitstream-level model
// checked every cycle, plus literal expectations for known loads.
module tb_config_loader;

  localparam int LEN = 20;
  localparam int CLR = 4;
  localparam int NB  = (LEN + 7) / 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_valid = 1'b0;
  logic       chain_config_out = 1'b0;
  logic       byte_ready;
  logic       chain_config_in;
  logic       chain_config_enable;
  logic       chain_config_nreset;
  logic       busy;
  logic       done;
  logic       error;

  always #5 clock = ~clock;

  config_loader #(
    .CHAIN_LENGTH (LEN),
    .CLEAR_CYCLES (CLR)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .byte_data           (byte_data),
    .byte_valid          (byte_valid),
    .byte_ready          (byte_ready),
    .chain_config_in     (chain_config_in),
    .chain_config_enable (chain_config_enable),
    .chain_config_nreset (chain_config_nreset),
    .chain_config_out    (chain_config_out),
    .busy                (busy),
    .done                (done),
    .error               (error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int got,
                     input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d",
               name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout, required event", name);
  endtask

  // bitstream model
  logic [7:0] tx_bytes[$];
  bit         exp_q[$];
  int  k = 0, shifts = 0, acc_cnt = 0, nlow = 0, gaps = 0;
  int  last_en_k = -100, fault_idx = -1;
  bit  loading = 0, exp_done = 0, exp_err = 0, err_pend = 0;
  bit  mon_on = 0, contiguous = 0, abort = 0;
  logic [LEN-1:0] got_bits = '0;

  always @(negedge clock) begin
    bit cfo;
    bit rdy_off;
    cfo = 1'b0;
    if (!reset && mon_on) begin
      if (err_pend) begin
        exp_err  = 1'b1;
        err_pend = 1'b0;
      end
      if (loading && !exp_done && shifts == LEN &&
          k == last_en_k + 1) begin
        exp_done = 1'b1;
        chk("bits_shifted", shifts, LEN);
        chk("model_bits_left", exp_q.size(), 0);
        chk("nreset_low_cycles", nlow, CLR);
        chk("bytes_taken", acc_cnt, NB);
        if (contiguous) chk("enable_gaps", gaps, 0);
      end
      chk("nreset", chain_config_nreset,
          (loading && k < CLR) ? 0 : 1);
      chk("busy", busy, int'(loading && !exp_done));
      chk("done", done, int'(exp_done));
      chk("error", error, int'(exp_err));
      if (!chain_config_nreset) nlow++;
      rdy_off = !loading || k < CLR || exp_done ||
                acc_cnt >= NB;
      if (rdy_off) chk("byte_ready_off", byte_ready, 0);
      if (byte_valid && byte_ready) acc_cnt++;
      if (chain_config_enable) begin
        chk("enable_window", int'(loading && k >= CLR &&
            !exp_done && shifts < LEN), 1);
        if (exp_q.size() > 0)
          chk("config_in", chain_config_in, exp_q.pop_front());
        if (shifts < LEN) got_bits[shifts] = chain_config_in;
        if (shifts > 0 && last_en_k != k - 1) gaps++;
        last_en_k = k;
        shifts++;
        if (shifts - 1 == fault_idx) begin
          cfo      = 1'b1;
          err_pend = 1'b1;
        end
      end
      k++;
    end
    chain_config_out = cfo;
  end

  task automatic fill_random();
    tx_bytes.delete();
    repeat (NB) tx_bytes.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic do_start();
    exp_q.delete();
    for (int i = 0; i < LEN; i++)
      exp_q.push_back(tx_bytes[i / 8][i % 8]);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    k         = 0;
    loading   = 1'b1;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    err_pend  = 1'b0;
    shifts    = 0;
    acc_cnt   = 0;
    nlow      = 0;
    gaps      = 0;
    last_en_k = -100;
    got_bits  = '0;
  endtask

  task automatic drive_bytes(input int gapmax, input int fixed_gap);
    for (int b = 0; b < tx_bytes.size() && !abort; b++) begin
      int g;
      int t;
      g = (fixed_gap >= 0) ? fixed_gap
                           : int'($urandom_range(gapmax, 0));
      repeat (g) @(posedge clock);
      if (g > 0) #1;
      byte_valid = 1'b1;
      byte_data  = tx_bytes[b];
      t = 0;
      do begin
        @(negedge clock);
        t++;
      end while (!byte_ready && !abort && t < 3000);
      if (t >= 3000) fail_now("byte_accept_timeout");
      @(posedge clock);
      #1;
      byte_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!exp_done && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (!exp_done) fail_now("done_timeout");
  endtask

  task automatic mid_start();
    int t;
    t = 0;
    while (shifts < 10 && t < 3000) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic run_load(input int gapmax, input int fixed_gap,
                          input int fault, input bit mid);
    fault_idx = fault;
    do_start();
    fork
      drive_bytes(gapmax, fixed_gap);
      wait_done();
      if (mid) mid_start();
    join
    repeat (2) @(negedge clock);
  endtask

  task automatic idle_entry(input string tag);
    #1;
    chk({tag, "_nreset_in_reset"}, chain_config_nreset, 0);
    @(posedge clock);
    #1;
    chk({tag, "_nreset_first_idle"}, chain_config_nreset, 1);
    mon_on = 1'b1;
  endtask

  initial begin
    int t;
    #1;
    chk("reset_outputs", {byte_ready, chain_config_in,
        chain_config_enable, chain_config_nreset, busy,
        done, error}, 0);
    #11;
    reset = 1'b0;
    idle_entry("por");

    // known stream, back-to-back bytes
    tx_bytes = '{8'hA5, 8'h3C, 8'hFF};
    contiguous = 1'b1;
    run_load(0, 0, -1, 1'b0);
    chk("load1_stream", got_bits, 32'h000F3CA5);
    chk("load1_enables", shifts, 20);
    chk("load1_error", error, 0);
    contiguous = 1'b0;

    // 20-cycle byte gaps starve the shifter
    fill_random();
    run_load(0, 20, -1, 1'b0);
    chk("gap_load_bubbles", int'(gaps > 0), 1);

    // a 1 on the fifth shift cycle
    fill_random();
    run_load(8, -1, 4, 1'b0);
    chk("fault_error_done", error, 1);
    repeat (3) @(negedge clock);
    chk("fault_error_held", error, 1);

    // restart clears error; start mid-load is ignored
    fill_random();
    run_load(6, -1, -1, 1'b1);
    chk("restart_error_clear", error, 0);
    chk("midstart_done", done, 1);

    // start from DONE
    fill_random();
    run_load(4, -1, -1, 1'b0);

    // reset around bit 7
    fill_random();
    fault_idx = -1;
    do_start();
    fork
      drive_bytes(2, -1);
      begin
        t = 0;
        while (shifts < 7 && t < 3000) begin
          @(negedge clock);
          t++;
        end
        if (shifts < 7) fail_now("bit7_timeout");
        #2;
        reset = 1'b1;
        #1;
        chk("midload_reset_outputs", {byte_ready,
            chain_config_in, chain_config_enable,
            chain_config_nreset, busy, done, error}, 0);
        abort  = 1'b1;
        mon_on = 1'b0;
      end
    join
    loading  = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    err_pend = 1'b0;
    abort    = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle_entry("mid");
    repeat (3) @(negedge clock);

    tx_bytes = '{8'h5A, 8'hC3, 8'h06};
    run_load(3, -1, -1, 1'b0);
    chk("post_reset_stream", got_bits, 32'h0006C35A);

    for (int n = 0; n < 4; n++) begin
      fill_random();
      run_load(int'($urandom_range(30, 0)), -1,
               int'($urandom_range(LEN + 5, 0)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
